// File: rtl/mash_dsm.sv
// MASH 1-1-1 delta-sigma modulator (order 1..3) driving a fractional-N divider.
// Emits a signed per-cycle correction and the resulting divide ratio n_int + correction.
module mash_dsm #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ORDER  = 3,
    parameter int unsigned NINT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [WIDTH-1:0]  frac,
    input  logic              frac_load,
    input  logic              dither_en,
    input  logic [NINT_W-1:0] n_int,
    output logic [3:0]        dsm_out,
    output logic [NINT_W-1:0] div_ratio,
    output logic              out_valid
);
    localparam int unsigned SUM_W  = WIDTH + 1;
    localparam int unsigned LFSR_W = 15;

    if (ORDER == 0 || ORDER > 3) begin : g_bad_order
        $error("mash_dsm: ORDER must be 1, 2 or 3");
    end

    logic [WIDTH-1:0]  frac_reg;
    logic [WIDTH-1:0]  acc1;
    logic [WIDTH-1:0]  acc2;
    logic [WIDTH-1:0]  acc3;
    logic              c2_d;
    logic              c3_d;
    logic              c3_dd;
    logic [LFSR_W-1:0] lfsr;
    logic              lfsr_fb;

    logic [SUM_W-1:0]  s1;
    logic [SUM_W-1:0]  s2;
    logic [SUM_W-1:0]  s3;
    logic              c1;
    logic              c2;
    logic              c3;
    logic [3:0]        y_c;
    logic [NINT_W-1:0] ratio_c;

    // x^15 + x^14 + 1 feedback; new bit enters at lfsr[0], the dither tap
    assign lfsr_fb = lfsr[LFSR_W-1] ^ lfsr[LFSR_W-2];

    // Cascaded accumulators and noise-cancellation network; unused stages stay at zero
    always_comb begin
        s1 = SUM_W'(acc1) + SUM_W'(frac_reg) + SUM_W'(dither_en & lfsr[0]);
        s2 = '0;
        s3 = '0;
        if (ORDER >= 2) begin
            s2 = SUM_W'(acc2) + SUM_W'(s1[WIDTH-1:0]);
        end
        if (ORDER >= 3) begin
            s3 = SUM_W'(acc3) + SUM_W'(s2[WIDTH-1:0]);
        end
        c1 = s1[WIDTH];
        c2 = s2[WIDTH];
        c3 = s3[WIDTH];

        // 4-bit modular arithmetic yields the two's complement result directly
        y_c = 4'(c1);
        if (ORDER >= 2) begin
            y_c = y_c + 4'(c2) - 4'(c2_d);
        end
        if (ORDER >= 3) begin
            y_c = y_c + 4'(c3) - {2'b00, c3_d, 1'b0} + 4'(c3_dd);
        end
        ratio_c = n_int + NINT_W'($signed(y_c));
    end

    // Modulator state, fraction register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frac_reg  <= '0;
            acc1      <= '0;
            acc2      <= '0;
            acc3      <= '0;
            c2_d      <= 1'b0;
            c3_d      <= 1'b0;
            c3_dd     <= 1'b0;
            lfsr      <= LFSR_W'(1);
            dsm_out   <= '0;
            div_ratio <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= en;
            if (frac_load) begin
                frac_reg <= frac;
            end
            if (en) begin
                acc1      <= s1[WIDTH-1:0];
                acc2      <= s2[WIDTH-1:0];
                acc3      <= s3[WIDTH-1:0];
                c2_d      <= c2;
                c3_dd     <= c3_d;
                c3_d      <= c3;
                lfsr      <= {lfsr[LFSR_W-2:0], lfsr_fb};
                dsm_out   <= y_c;
                div_ratio <= ratio_c;
            end
        end
    end

endmodule

// File: tb/tb_mash_dsm.sv
// Scoreboarded bench for mash_dsm: three instances (ORDER 1, 2, 3) share stimulus and are
// compared each cycle against an arithmetic reference model.
module tb_mash_dsm;
    localparam int unsigned W   = 16;
    localparam int unsigned NW  = 8;
    localparam longint      MOD = longint'(1) << W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          frac_load = 1'b0;
    logic          dither_en = 1'b0;
    logic [W-1:0]  frac = '0;
    logic [NW-1:0] n_int = '0;

    logic [3:0]    dsm_out   [3];
    logic [NW-1:0] div_ratio [3];
    logic          out_valid [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mash_dsm #(.WIDTH(W), .ORDER(g + 1), .NINT_W(NW)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .frac      (frac),
            .frac_load (frac_load),
            .dither_en (dither_en),
            .n_int     (n_int),
            .dsm_out   (dsm_out[g]),
            .div_ratio (div_ratio[g]),
            .out_valid (out_valid[g])
        );
    end

    typedef struct packed {
        logic            v;
        logic [2:0][3:0] d;
        logic [2:0][7:0] r;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    // Reference model state, one slot per order (index k => ORDER k+1)
    longint m_a1 [3];
    longint m_a2 [3];
    longint m_a3 [3];
    int     m_c2d [3];
    int     m_c3d [3];
    int     m_c3dd [3];
    int     m_y [3];
    int     m_r [3];
    int     m_lfsr;
    longint m_frac;

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_a1[k] = 0; m_a2[k] = 0; m_a3[k] = 0;
            m_c2d[k] = 0; m_c3d[k] = 0; m_c3dd[k] = 0;
            m_y[k] = 0; m_r[k] = 0;
        end
        m_lfsr = 1;
        m_frac = 0;
    endfunction

    // Predict the outputs after the coming rising edge from the inputs now applied
    function automatic void model_edge();
        exp_t e;
        int   d;
        if (!rst_n) begin
            model_reset();
            sbq.push_back('0);
            return;
        end
        if (en) begin
            d = dither_en ? (m_lfsr & 1) : 0;
            for (int k = 0; k < 3; k++) begin
                longint t;
                int c1, c2, c3, y;
                t = m_a1[k] + m_frac + longint'(d);
                c1 = int'(t / MOD); m_a1[k] = t % MOD;
                c2 = 0; c3 = 0;
                if (k >= 1) begin
                    t = m_a2[k] + m_a1[k];
                    c2 = int'(t / MOD); m_a2[k] = t % MOD;
                end
                if (k >= 2) begin
                    t = m_a3[k] + m_a2[k];
                    c3 = int'(t / MOD); m_a3[k] = t % MOD;
                end
                y = c1;
                if (k >= 1) y = y + c2 - m_c2d[k];
                if (k >= 2) y = y + c3 - 2 * m_c3d[k] + m_c3dd[k];
                m_c2d[k] = c2;
                m_c3dd[k] = m_c3d[k];
                m_c3d[k] = c3;
                m_y[k] = y;
                m_r[k] = (int'(n_int) + y) & 255;
            end
            m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1)) & 32'h7fff;
        end
        if (frac_load) m_frac = longint'(frac);
        e.v = en;
        for (int k = 0; k < 3; k++) begin
            e.d[k] = 4'(m_y[k]);
            e.r[k] = 8'(m_r[k]);
        end
        sbq.push_back(e);
    endfunction

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: one expected entry per rising edge, compared for all three instances
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (out_valid[k] !== mon_e.v || dsm_out[k] !== mon_e.d[k] ||
                        div_ratio[k] !== mon_e.r[k]) begin
                        failures++;
                        $display("FAIL sb_order%0d t=%0t: got v=%0b dsm=%0d div=%0d, want v=%0b dsm=%0d div=%0d",
                                 k + 1, $time, out_valid[k], $signed(dsm_out[k]), div_ratio[k],
                                 mon_e.v, $signed(mon_e.d[k]), mon_e.r[k]);
                    end
                end
            end
        end
    end

    task automatic step(input logic e, input logic ld, input logic [W-1:0] f,
                        input logic de, input logic [NW-1:0] ni);
        @(negedge clk);
        en = e; frac_load = ld; frac = f; dither_en = de; n_int = ni;
        model_edge();
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear immediately
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0; en = 1'b0; frac_load = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_async_dsm%0d", k + 1), longint'(dsm_out[k]), 0);
            chk($sformatf("rst_async_div%0d", k + 1), longint'(div_ratio[k]), 0);
            chk($sformatf("rst_async_vld%0d", k + 1), longint'(out_valid[k]), 0);
        end
        model_edge();
        @(posedge clk);
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        model_edge();
    endtask

    int seq1 [6] = '{0, 1, 1, 1, 1, 0};
    int ones;
    int sum;
    int bad;

    initial begin
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_dsm%0d", k + 1), longint'(dsm_out[k]), 0);
            chk($sformatf("reset_div%0d", k + 1), longint'(div_ratio[k]), 0);
            chk($sformatf("reset_vld%0d", k + 1), longint'(out_valid[k]), 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_edge();

        // First-order pattern and exact density for 0xCCCD over one full period
        step(1'b0, 1'b1, 16'hCCCD, 1'b0, 8'd10);
        ones = 0;
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, 1'b0, 16'hCCCD, 1'b0, 8'd10);
            if (i < 6) chk($sformatf("t1_seq%0d", i), longint'(dsm_out[0]), longint'(seq1[i]));
            if (dsm_out[0] == 4'd1) ones++;
        end
        chk("t1_ones", longint'(ones), 52429);

        // Third order at one half: bounded output, exact mean over 2048 steps
        pulse_reset();
        step(1'b0, 1'b1, 16'h8000, 1'b0, 8'd40);
        sum = 0; bad = 0;
        for (int i = 0; i < 2048; i++) begin
            step(1'b1, 1'b0, 16'h8000, 1'b0, 8'd40);
            sum += int'($signed(dsm_out[2]));
            if ($signed(dsm_out[2]) < -4'sd3 || $signed(dsm_out[2]) > 4'sd4) bad++;
            if (div_ratio[2] !== 8'(40 + int'($signed(dsm_out[2])))) bad++;
        end
        chk("t2_sum", longint'(sum), 1024);
        chk("t2_range_div", longint'(bad), 0);

        // Zero fraction without dither: flat output at n_int
        pulse_reset();
        step(1'b0, 1'b1, 16'h0000, 1'b0, 8'd77);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b0, 16'h0000, 1'b0, 8'd77);
            for (int k = 0; k < 3; k++) begin
                if (dsm_out[k] !== 4'd0 || div_ratio[k] !== 8'd77) bad++;
            end
        end
        chk("t3_flat", longint'(bad), 0);

        // Enable gap: outputs hold, valid drops, sequence resumes seamlessly
        pulse_reset();
        step(1'b0, 1'b1, 16'h4000, 1'b0, 8'd20);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 16'h4000, 1'b0, 8'd20);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 16'h4000, 1'b0, 8'd20);
            chk($sformatf("t4_gap_vld%0d", i), longint'(out_valid[1]), 0);
        end
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 16'h4000, 1'b0, 8'd20);

        // Fraction load coincident with an enabled step
        pulse_reset();
        step(1'b0, 1'b1, 16'h2000, 1'b0, 8'd30);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h2000, 1'b0, 8'd30);
        step(1'b1, 1'b1, 16'h1000, 1'b0, 8'd30);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 16'h1000, 1'b0, 8'd30);

        // Randomised run with dither, loads, enable gaps and a mid-run reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) pulse_reset();
            step(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 19) == 0),
                 W'($urandom), logic'($urandom_range(0, 1)), NW'($urandom_range(3, 251)));
        end

        @(posedge clk);
        #2;
        chk("sb_drain", longint'(sbq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
